// File: rtl/spi_transfer_sequencer.sv
// spi_transfer_sequencer: buffers TX words in a small FIFO, launches one SPI transfer per word,
// tracks completion via chip select and returns the captured word through an RX holding register.
module spi_transfer_sequencer #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [DATA_W-1:0]           rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic                        spi_start,
    output logic [DATA_W-1:0]           spi_data_in,
    input  logic [DATA_W-1:0]           spi_data_out,
    input  logic                        spi_cs,
    output logic                        busy,
    output logic                        timeout_err,
    output logic [$clog2(FIFO_DEPTH):0] tx_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [LVL_W-1:0] LvlFull = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitCsLo,
        StWaitCsHi,
        StCapture
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]    level_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   data_in_q;
    logic [DATA_W-1:0]   rx_data_q;
    logic                rx_valid_q;
    logic                push, pop, capture, cnt_clr, cnt_inc, timeout;

    // Ready depends only on registered occupancy, so a full FIFO refuses a push even when
    // the FSM pops in the same cycle.
    assign tx_ready    = (level_q != LvlFull);
    assign push        = tx_valid & tx_ready;
    assign tx_level    = level_q;
    assign spi_start   = (state_q == StLaunch);
    assign spi_data_in = data_in_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign busy        = (state_q != StIdle);
    assign timeout_err = timeout;

    // FIFO storage write; contents need no reset since level/pointers gate every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally for power-of-two depth
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; timeout takes precedence over a CS edge in the same WAIT cycle
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Uses registered rx_valid, so a same-cycle RX pop delays launch by one cycle
                if ((level_q != '0) && !rx_valid_q && spi_cs) begin
                    pop     = 1'b1;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                cnt_clr = 1'b1;
                state_d = StWaitCsLo;
            end
            StWaitCsLo: begin
                if (cnt_q == CntLast) begin
                    timeout = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = StIdle;
                end else if (!spi_cs) begin
                    cnt_clr = 1'b1;
                    state_d = StWaitCsHi;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            StWaitCsHi: begin
                if (cnt_q == CntLast) begin
                    timeout = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = StIdle;
                end else if (spi_cs) begin
                    cnt_clr = 1'b1;
                    state_d = StCapture;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            StCapture: begin
                capture = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Per-WAIT-state cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (cnt_inc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Word presented to the SPI top, held from launch until the next pop
    always_ff @(posedge clk) begin
        if (reset) begin
            data_in_q <= '0;
        end else if (pop) begin
            data_in_q <= fifo_mem[rd_ptr_q];
        end
    end

    // RX holding register; launch is blocked while full, so capture never overwrites
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else if (capture) begin
            rx_data_q  <= spi_data_out;
            rx_valid_q <= 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_transfer_sequencer.sv
// Directed self-checking bench for spi_transfer_sequencer.
module tb_spi_transfer_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    // Main DUT (default timeout)
    logic [31:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        spi_start;
    logic [31:0] spi_data_in;
    logic [31:0] spi_data_out = '0;
    logic        spi_cs = 1'b1;
    logic        busy;
    logic        timeout_err;
    logic [2:0]  tx_level;

    // Second DUT with a short timeout
    logic [31:0] t_tx_data = '0;
    logic        t_tx_valid = 1'b0;
    logic        t_tx_ready;
    logic [31:0] t_rx_data;
    logic        t_rx_valid;
    logic        t_rx_ready = 1'b0;
    logic        t_spi_start;
    logic [31:0] t_spi_data_in;
    logic [31:0] t_spi_data_out = '0;
    logic        t_spi_cs = 1'b1;
    logic        t_busy;
    logic        t_timeout_err;
    logic [2:0]  t_tx_level;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_transfer_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .spi_start    (spi_start),
        .spi_data_in  (spi_data_in),
        .spi_data_out (spi_data_out),
        .spi_cs       (spi_cs),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .tx_level     (tx_level)
    );

    spi_transfer_sequencer #(
        .TIMEOUT_CYC (16)
    ) dut_to (
        .clk          (clk),
        .reset        (reset),
        .tx_data      (t_tx_data),
        .tx_valid     (t_tx_valid),
        .tx_ready     (t_tx_ready),
        .rx_data      (t_rx_data),
        .rx_valid     (t_rx_valid),
        .rx_ready     (t_rx_ready),
        .spi_start    (t_spi_start),
        .spi_data_in  (t_spi_data_in),
        .spi_data_out (t_spi_data_out),
        .spi_cs       (t_spi_cs),
        .busy         (t_busy),
        .timeout_err  (t_timeout_err),
        .tx_level     (t_tx_level)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    task automatic rx_pop(input string tag);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        check({tag, "_rxpop"}, rx_valid, 1'b0);
    endtask

    // Play the SPI top for one transfer: CS low for low_cyc cycles, then high with result
    task automatic spi_xfer(input string tag, input bit wait_start, input logic [31:0] exp_din,
                            input logic [31:0] ret, input int low_cyc);
        if (wait_start) begin
            for (int i = 0; i < 20 && !spi_start; i++) step();
            check({tag, "_start"}, spi_start, 1'b1);
        end
        check({tag, "_din"}, spi_data_in, exp_din);
        step();
        spi_cs       = 1'b0;
        spi_data_out = ret;
        repeat (low_cyc) step();
        check({tag, "_hold"}, spi_data_in, exp_din);
        spi_cs = 1'b1;
        step();
        check({tag, "_rxv_early"}, rx_valid, 1'b0);
        step();
        check({tag, "_rxv"}, rx_valid, 1'b1);
        check({tag, "_rxd"}, rx_data, ret);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w2 [5];
        logic [31:0] f7 [4];
        bit          seen;

        w2 = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003, 32'h5555_0004};
        f7 = '{32'h7000_0001, 32'h7000_0002, 32'h7000_0003, 32'h7000_0004};

        // Reset state
        step();
        step();
        reset = 1'b0;
        check("rst_level", tx_level, 3'd0);
        check("rst_txrdy", tx_ready, 1'b1);
        check("rst_rxv", rx_valid, 1'b0);
        check("rst_rxd", rx_data, 32'h0);
        check("rst_start", spi_start, 1'b0);
        check("rst_din", spi_data_in, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_to", timeout_err, 1'b0);

        // T1: single word, start two cycles after the push
        push_word(32'hA5A5_0001);
        check("t1_lvl1", tx_level, 3'd1);
        check("t1_busy0", busy, 1'b0);
        check("t1_start0", spi_start, 1'b0);
        step();
        check("t1_start1", spi_start, 1'b1);
        check("t1_lvl0", tx_level, 3'd0);
        check("t1_busy1", busy, 1'b1);
        spi_xfer("t1", 1'b0, 32'hA5A5_0001, 32'h1234_5678, 40);
        step();
        check("t1_rxv_held", rx_valid, 1'b1);
        check("t1_busy_idle", busy, 1'b0);
        rx_pop("t1");

        // T2: fill while CS stays high; first word launches, ready drops after the fifth
        begin
            logic [2:0] exp_lvl [5];
            logic       exp_rdy [5];
            exp_lvl = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
            exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            for (int i = 0; i < 5; i++) begin
                tx_data  = w2[i];
                tx_valid = 1'b1;
                step();
                check($sformatf("t2_lvl%0d", i), tx_level, exp_lvl[i]);
                check($sformatf("t2_rdy%0d", i), tx_ready, exp_rdy[i]);
            end
            tx_data = 32'hDEAD_BEEF;
            step();
            tx_valid = 1'b0;
            check("t2_full_lvl", tx_level, 3'd4);
        end
        for (int i = 0; i < 5; i++) begin
            spi_xfer($sformatf("t2_%0d", i), i != 0, w2[i], w2[i] ^ 32'hFFFF_0000, 3);
            rx_pop($sformatf("t2_%0d", i));
        end
        check("t2_lvl_end", tx_level, 3'd0);

        // T3: RX backpressure holds the second launch
        push_word(32'h3000_000A);
        push_word(32'h3000_000B);
        spi_xfer("t3a", 1'b1, 32'h3000_000A, 32'hC0DE_000A, 3);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen |= spi_start;
        end
        check("t3_no_start", seen, 1'b0);
        check("t3_lvl1", tx_level, 3'd1);
        check("t3_rxd_kept", rx_data, 32'hC0DE_000A);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        check("t3_rxv_clr", rx_valid, 1'b0);
        check("t3_start_late", spi_start, 1'b0);
        step();
        check("t3_start", spi_start, 1'b1);
        spi_xfer("t3b", 1'b1, 32'h3000_000B, 32'hC0DE_000B, 3);

        // T6: level 2, push during the launch pop cycle -> level stays 2, order kept
        push_word(32'h6000_000C);
        push_word(32'h6000_000D);
        check("t6_lvl2", tx_level, 3'd2);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        tx_data  = 32'h6000_000E;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        check("t6_lvl_same", tx_level, 3'd2);
        check("t6_start", spi_start, 1'b1);
        spi_xfer("t6c", 1'b1, 32'h6000_000C, 32'hC0DE_000C, 3);
        rx_pop("t6c");
        spi_xfer("t6d", 1'b1, 32'h6000_000D, 32'hC0DE_000D, 3);
        rx_pop("t6d");
        spi_xfer("t6e", 1'b1, 32'h6000_000E, 32'hC0DE_000E, 3);

        // T7: full FIFO, push during launch pop cycle is refused
        for (int i = 0; i < 4; i++) push_word(f7[i]);
        check("t7_full", tx_level, 3'd4);
        check("t7_rdy0", tx_ready, 1'b0);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        tx_data  = 32'hBAD0_BAD0;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        check("t7_lvl3", tx_level, 3'd3);
        for (int i = 0; i < 4; i++) begin
            spi_xfer($sformatf("t7_%0d", i), 1'b1, f7[i], ~f7[i], 2);
            rx_pop($sformatf("t7_%0d", i));
        end
        step();
        check("t7_lvl_end", tx_level, 3'd0);
        check("t7_busy_end", busy, 1'b0);

        // T5: reset during WAIT_CS_HI with three words queued
        for (int i = 0; i < 4; i++) push_word(32'h5000_0000 + i);
        spi_cs = 1'b0;
        step();
        check("t5_busy_pre", busy, 1'b1);
        check("t5_lvl_pre", tx_level, 3'd3);
        reset = 1'b1;
        step();
        reset  = 1'b0;
        spi_cs = 1'b1;
        check("t5_lvl", tx_level, 3'd0);
        check("t5_busy", busy, 1'b0);
        check("t5_rxv", rx_valid, 1'b0);
        check("t5_start", spi_start, 1'b0);
        check("t5_din", spi_data_in, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen |= spi_start | rx_valid;
        end
        check("t5_quiet", seen, 1'b0);

        // T4: CS never falls; timeout 16 cycles after LAUNCH, then next word launches
        t_tx_data  = 32'h4000_0001;
        t_tx_valid = 1'b1;
        step();
        t_tx_data  = 32'h4000_0002;
        step();
        t_tx_valid = 1'b0;
        for (int i = 0; i < 20 && !t_spi_start; i++) step();
        check("t4_start1", t_spi_start, 1'b1);
        check("t4_din1", t_spi_data_in, 32'h4000_0001);
        seen = 1'b0;
        for (int k = 1; k < 16; k++) begin
            step();
            seen |= t_timeout_err;
        end
        check("t4_early", seen, 1'b0);
        step();
        check("t4_to", t_timeout_err, 1'b1);
        step();
        check("t4_to_pulse", t_timeout_err, 1'b0);
        check("t4_busy", t_busy, 1'b0);
        check("t4_rxv", t_rx_valid, 1'b0);
        step();
        check("t4_start2", t_spi_start, 1'b1);
        check("t4_din2", t_spi_data_in, 32'h4000_0002);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
